// File: rtl/hcla_addsub_pipe.sv
// Pipelined hierarchical carry-lookahead adder/subtractor (4-bit groups, 16-bit blocks).
// Latency: 3 register stages; result visible three cycles after the operands are presented.
// Backpressure: each stage holds while the next is full and stalled; in_ready follows out_ready combinationally.
module hcla_addsub_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             borrow,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int NG = WIDTH / 4;   // 4-bit groups
  localparam int NB = WIDTH / 16;  // 16-bit blocks

  // stage valids and advance terms
  logic v1, v2;
  logic adv1, adv2, adv3;

  // S1 state: bit generate/propagate; op doubles as the carry-in
  logic [WIDTH-1:0] s1_g, s1_p;
  logic             s1_op;

  // S2 state: bit propagate, low three generates of each group, group carry-ins, carry out
  logic [WIDTH-1:0]      s2_p;
  logic [NG-1:0][2:0]    s2_g;
  logic [NG-1:0]         s2_gc;
  logic                  s2_cout;
  logic                  s2_op;

  // combinational helpers
  logic [WIDTH-1:0] b_eff;
  logic [NG-1:0]    gg, gp, gc;
  logic [NB-1:0]    bg, bp;
  logic             bcarry;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] sum;

  assign adv3     = !out_valid || out_ready;
  assign adv2     = !v2 || adv3;
  assign adv1     = !v1 || adv2;
  assign in_ready = adv1;

  // subtraction uses the complement path: a + ~b + 1
  assign b_eff = op ? ~b : b;

  // S1 register: capture bit-level g/p on a transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      s1_g  <= '0;
      s1_p  <= '0;
      s1_op <= 1'b0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_g  <= a & b_eff;
        s1_p  <= a ^ b_eff;
        s1_op <= op;
      end
    end
  end

  // group and block lookahead; block carries ripple from cin, then group carry-ins per block
  always_comb begin
    gg     = '0;
    gp     = '0;
    gc     = '0;
    bg     = '0;
    bp     = '0;
    bcarry = s1_op;
    for (int k = 0; k < NG; k++) begin
      gg[k] = s1_g[4*k+3]
            | (s1_p[4*k+3] & s1_g[4*k+2])
            | (s1_p[4*k+3] & s1_p[4*k+2] & s1_g[4*k+1])
            | ((&s1_p[4*k+1 +: 3]) & s1_g[4*k]);
      gp[k] = &s1_p[4*k +: 4];
    end
    for (int j = 0; j < NB; j++) begin
      bg[j] = gg[4*j+3]
            | (gp[4*j+3] & gg[4*j+2])
            | (gp[4*j+3] & gp[4*j+2] & gg[4*j+1])
            | ((&gp[4*j+1 +: 3]) & gg[4*j]);
      bp[j] = &gp[4*j +: 4];
      gc[4*j]   = bcarry;
      gc[4*j+1] = gg[4*j] | (gp[4*j] & bcarry);
      gc[4*j+2] = gg[4*j+1] | (gp[4*j+1] & gg[4*j]) | (gp[4*j+1] & gp[4*j] & bcarry);
      gc[4*j+3] = gg[4*j+2] | (gp[4*j+2] & gg[4*j+1]) | (gp[4*j+2] & gp[4*j+1] & gg[4*j])
                | ((&gp[4*j +: 3]) & bcarry);
      bcarry = bg[j] | (bp[j] & bcarry);
    end
  end

  // S2 register: forward p, the generates S3 still needs, group carry-ins and the final carry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2      <= 1'b0;
      s2_p    <= '0;
      s2_g    <= '0;
      s2_gc   <= '0;
      s2_cout <= 1'b0;
      s2_op   <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        s2_p    <= s1_p;
        for (int k = 0; k < NG; k++) s2_g[k] <= s1_g[4*k +: 3];
        s2_gc   <= gc;
        s2_cout <= bcarry;
        s2_op   <= s1_op;
      end
    end
  end

  // bit carries inside each group from its carry-in, then sum
  always_comb begin
    c = '0;
    for (int k = 0; k < NG; k++) begin
      c[4*k]   = s2_gc[k];
      c[4*k+1] = s2_g[k][0] | (s2_p[4*k] & s2_gc[k]);
      c[4*k+2] = s2_g[k][1] | (s2_p[4*k+1] & s2_g[k][0]) | (s2_p[4*k+1] & s2_p[4*k] & s2_gc[k]);
      c[4*k+3] = s2_g[k][2] | (s2_p[4*k+2] & s2_g[k][1]) | (s2_p[4*k+2] & s2_p[4*k+1] & s2_g[k][0])
               | ((&s2_p[4*k +: 3]) & s2_gc[k]);
    end
    sum = s2_p ^ c;
  end

  // S3 register: result and flags, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      borrow    <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
    end else if (adv3) begin
      out_valid <= v2;
      if (v2) begin
        result <= sum;
        cout   <= s2_cout;
        borrow <= s2_op & ~s2_cout;
        zero   <= (sum == '0);
        neg    <= sum[WIDTH-1];
        ovf    <= c[WIDTH-1] ^ s2_cout;
      end
    end
  end

endmodule

// File: tb/tb_hcla_addsub_pipe.sv
// Randomized bench for hcla_addsub_pipe against an arithmetic reference model.
// Checks reset state, directed corner cases, latency, backpressure, stall stability and mid-stream reset.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_hcla_addsub_pipe;

  localparam int W = 32;
  typedef logic [W+4:0] exp_t;  // {result, cout, borrow, zero, neg, ovf}

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         op = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         cout, borrow, zero, neg, ovf;

  hcla_addsub_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .borrow(borrow), .zero(zero), .neg(neg), .ovf(ovf)
  );

  always #5 clk = ~clk;

  wire exp_t obs = {result, cout, borrow, zero, neg, ovf};

  exp_t          q[$];
  int            tq[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            n_acc = 0;
  int            n_out = 0;
  bit            lat_chk = 1'b0;
  bit            accepted = 1'b0;
  bit            held_vld = 1'b0;
  logic [W+5:0]  held_val = '0;

  // reference: unsigned compare gives carry/no-borrow, sign rules give overflow
  function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y, logic o);
    logic [W-1:0] r;
    logic         c, ov;
    if (!o) begin
      r  = x + y;
      c  = (r < x);
      ov = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    end else begin
      r  = x - y;
      c  = (x >= y);
      ov = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    end
    return {r, c, o & ~c, (r == '0), r[W-1], ov};
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  task automatic new_ops();
    a  = pick();
    b  = pick();
    op = 1'($urandom_range(0, 1));
  endtask

  // one cycle: monitor at falling edge, then return 1 unit after the rising edge
  task automatic tick();
    @(negedge clk);
    accepted = 1'b0;
    if (rst_n) begin
      if (held_vld) check("stall_hold", {out_valid, obs}, held_val);
      held_vld = out_valid && !out_ready;
      held_val = {out_valid, obs};
      if (out_valid && out_ready) begin
        n_out++;
        check("pop_has_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          exp_t e = q.pop_front();
          int   t = tq.pop_front();
          check("result_flags", obs, e);
          if (lat_chk) check("latency", cyc - t, 3);
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, op));
        tq.push_back(cyc);
        n_acc++;
        accepted = 1'b1;
      end
    end else begin
      held_vld = 1'b0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 50 && q.size() > 0; i++) tick();
    check("drain_empty", q.size(), 0);
  endtask

  // single op with free-flowing output; checks against spelled-out constants as well
  task automatic send(string tag, logic [W-1:0] x, logic [W-1:0] y, logic o, exp_t expc);
    a = x; b = y; op = o; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check({tag, "_vld"}, out_valid, 1);
    check(tag, obs, expc);
    tick();
  endtask

  initial begin
    // reset with random inputs
    out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      new_ops();
      in_valid  = 1'b1;
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_outputs", obs, 0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    #1;
    check("in_ready_after_rst", in_ready, 1);

    // directed corner cases
    lat_chk = 1'b1;
    send("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, {32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    send("sub_borrow", 32'h0000_0003, 32'h0000_0005, 1'b1, {32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
    send("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b1, {32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
    send("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, {32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    send("sub_equal", 32'h1234_5678, 32'h1234_5678, 1'b1, {32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});

    // back-to-back throughput with out_ready high
    for (int i = 0; i < 20; i++) begin
      new_ops();
      in_valid = 1'b1;
      tick();
    end
    drain();
    lat_chk = 1'b0;

    // backpressure: 8 ops, consumer stalled, then toggling
    n_acc = 0;
    n_out = 0;
    out_ready = 1'b0;
    new_ops();
    in_valid = 1'b1;
    repeat (6) begin
      tick();
      if (accepted) new_ops();
    end
    check("bp_accepts", n_acc, 3);
    check("bp_in_ready_low", in_ready, 0);
    for (int i = 0; i < 200 && n_acc < 8; i++) begin
      out_ready = ~out_ready;
      tick();
      if (accepted) new_ops();
    end
    in_valid = 1'b0;
    drain();
    check("bp_outputs", n_out, 8);

    // mid-stream reset with three ops in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (4) begin
      tick();
      if (accepted) new_ops();
    end
    check("pre_rst_inflight", q.size(), 3);
    rst_n = 1'b0;
    q.delete();
    tq.delete();
    tick();
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    check("post_rst_out_valid", out_valid, 0);
    n_out = 0;
    out_ready = 1'b1;
    repeat (10) tick();
    check("post_rst_no_output", n_out, 0);

    // random scoreboard
    for (int i = 0; i < 10000; i++) begin
      new_ops();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
